// File: rtl/add_tree_acc_if.sv
// Operand/result bus of the adder-tree accumulator.
// The master drives operands and beat flags; the slave returns the saturated result.
interface add_tree_acc_if #(
    parameter int unsigned OP_CNT   = 8,
    parameter int unsigned DATA_WDT = 16
);
    logic [OP_CNT*DATA_WDT-1:0] in_ops;
    logic [OP_CNT-1:0]          in_op_msk;
    logic                       in_val;
    logic                       in_acc_en;
    logic                       in_last;
    logic [DATA_WDT-1:0]        out_res;
    logic                       out_val;
    logic                       out_sat;

    modport master (
        output in_ops, in_op_msk, in_val, in_acc_en, in_last,
        input  out_res, out_val, out_sat
    );

    modport slave (
        input  in_ops, in_op_msk, in_val, in_acc_en, in_last,
        output out_res, out_val, out_sat
    );
endinterface

// File: rtl/add_tree_acc.sv
// Pipelined masked adder tree with an output-saturating accumulator.
// Each tree level is one register stage; the accumulator/output register follows the last level.
module add_tree_acc #(
    parameter int unsigned OP_CNT        = 8,
    parameter int unsigned DATA_WDT      = 16,
    parameter int unsigned ACC_GUARD_WDT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    add_tree_acc_if.slave bus
);
    localparam int unsigned LVL = (OP_CNT > 1) ? $clog2(OP_CNT) : 0;
    localparam int unsigned TW  = DATA_WDT + LVL;
    localparam int unsigned AW  = TW + ACC_GUARD_WDT;
    localparam int unsigned AW1 = AW + 1;

    localparam logic signed [AW-1:0] A_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] A_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [AW-1:0] D_MAX = AW'({1'b0, {(DATA_WDT-1){1'b1}}});
    localparam logic signed [AW-1:0] D_MIN = ~D_MAX;

    // Element count of tree level k (level 0 = raw operands).
    function automatic int lvl_cnt(input int k);
        int c;
        c = int'(OP_CNT);
        for (int j = 0; j < k; j++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int clamp_idx(input int j);
        return (j < int'(OP_CNT)) ? j : int'(OP_CNT) - 1;
    endfunction

    // Masking happens before level 1; masked operands enter as zero.
    logic signed [TW-1:0] op_c [OP_CNT];
    always_comb begin
        for (int i = 0; i < int'(OP_CNT); i++) begin
            op_c[i] = bus.in_op_msk[i] ? TW'($signed(bus.in_ops[i*DATA_WDT +: DATA_WDT])) : '0;
        end
    end

    logic [2:0]           ctl_in_c;
    logic [2:0]           sctl_c;
    logic signed [TW-1:0] sum_c;

    assign ctl_in_c = {bus.in_val, bus.in_acc_en, bus.in_last};

    generate
        if (LVL == 0) begin : g_flat
            assign sum_c  = op_c[0];
            assign sctl_c = ctl_in_c;
        end else begin : g_tree
            logic signed [TW-1:0] node_q [LVL][OP_CNT];
            logic signed [TW-1:0] src_c  [LVL][OP_CNT];
            logic [2:0]           ctl_q  [LVL];

            always_comb begin
                for (int i = 0; i < int'(OP_CNT); i++) begin
                    src_c[0][i] = op_c[i];
                    for (int k = 1; k < int'(LVL); k++) src_c[k][i] = node_q[k-1][i];
                end
            end

            // Pair adjacent elements; an odd trailing element passes through to stay aligned.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < int'(LVL); k++) begin
                        ctl_q[k] <= '0;
                        for (int i = 0; i < int'(OP_CNT); i++) node_q[k][i] <= '0;
                    end
                end else if (clk_en) begin
                    for (int k = 0; k < int'(LVL); k++) begin
                        for (int i = 0; i < int'(OP_CNT); i++) begin
                            if (2*i + 1 < lvl_cnt(k))
                                node_q[k][i] <= src_c[k][clamp_idx(2*i)] + src_c[k][clamp_idx(2*i+1)];
                            else if (2*i < lvl_cnt(k))
                                node_q[k][i] <= src_c[k][clamp_idx(2*i)];
                            else
                                node_q[k][i] <= '0;
                        end
                    end
                    ctl_q[0] <= ctl_in_c;
                    for (int k = 1; k < int'(LVL); k++) ctl_q[k] <= ctl_q[k-1];
                end
            end

            assign sum_c  = node_q[LVL-1][0];
            assign sctl_c = ctl_q[LVL-1];
        end
    endgenerate

    typedef enum logic {IDLE, GROUP} state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 grp_sat_q, grp_sat_d;
    logic [DATA_WDT-1:0]  res_q, res_d;
    logic                 val_q, val_d;
    logic                 sat_q, sat_d;

    logic signed [AW-1:0] sum_ext;
    logic signed [AW:0]   wide;
    logic                 ovf;
    logic signed [AW-1:0] acc_nxt;
    logic signed [AW-1:0] result;
    logic                 close;
    logic                 close_sat;

    // Accumulator FSM and output saturation.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        grp_sat_d = grp_sat_q;
        res_d     = res_q;
        val_d     = 1'b0;
        sat_d     = sat_q;
        close     = 1'b0;
        close_sat = 1'b0;

        sum_ext = AW'(sum_c);
        wide    = AW1'(acc_q) + AW1'(sum_ext);
        ovf     = wide[AW] != wide[AW-1];
        acc_nxt = ovf ? (wide[AW] ? A_MIN : A_MAX) : wide[AW-1:0];
        result  = sum_ext;

        if (sctl_c[2]) begin
            if (!sctl_c[1]) begin
                close = 1'b1;
            end else if (!sctl_c[0]) begin
                if (state_q == IDLE) begin
                    acc_d     = sum_ext;
                    grp_sat_d = 1'b0;
                end else begin
                    acc_d     = acc_nxt;
                    grp_sat_d = grp_sat_q | ovf;
                end
                state_d = GROUP;
            end else begin
                close = 1'b1;
                if (state_q == GROUP) begin
                    result    = acc_nxt;
                    close_sat = grp_sat_q | ovf;
                end
                acc_d     = '0;
                grp_sat_d = 1'b0;
                state_d   = IDLE;
            end
        end

        if (close) begin
            val_d = 1'b1;
            if (result > D_MAX) begin
                res_d = DATA_WDT'(D_MAX);
                sat_d = 1'b1;
            end else if (result < D_MIN) begin
                res_d = DATA_WDT'(D_MIN);
                sat_d = 1'b1;
            end else begin
                res_d = DATA_WDT'(result);
                sat_d = close_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            grp_sat_q <= 1'b0;
            res_q     <= '0;
            val_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            grp_sat_q <= grp_sat_d;
            res_q     <= res_d;
            val_q     <= val_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.out_res = res_q;
    assign bus.out_val = val_q;
    assign bus.out_sat = sat_q;
endmodule

// File: tb/tb_add_tree_acc.sv
// Directed bench for add_tree_acc with OP_CNT=5 (three tree levels, latency 4).
module tb_add_tree_acc;
    localparam int unsigned OPN = 5;
    localparam int unsigned DW  = 16;

    logic clk;
    logic rst_n;
    logic clk_en;

    add_tree_acc_if #(.OP_CNT(OPN), .DATA_WDT(DW)) bus ();

    add_tree_acc #(.OP_CNT(OPN), .DATA_WDT(DW), .ACC_GUARD_WDT(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int q_edge[$];
    int q_res[$];
    int q_sat[$];

    // Collect every result produced on an enabled edge, tagged with its edge number.
    always @(posedge clk) begin
        logic en;
        en = clk_en;
        edge_cnt++;
        #1;
        if (bus.out_val && en && rst_n) begin
            q_edge.push_back(edge_cnt);
            q_res.push_back(int'($signed(bus.out_res)));
            q_sat.push_back(int'(bus.out_sat));
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [OPN*DW-1:0] ops5(input int a, input int b, input int c,
                                               input int d, input int e);
        return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [OPN*DW-1:0] fill(input int x);
        return ops5(x, x, x, x, x);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic beat(input logic [OPN*DW-1:0] ops, input logic [OPN-1:0] msk,
                        input logic acc, input logic last, output int e);
        bus.in_ops    = ops;
        bus.in_op_msk = msk;
        bus.in_val    = 1'b1;
        bus.in_acc_en = acc;
        bus.in_last   = last;
        @(posedge clk);
        #2;
        e = edge_cnt;
        bus.in_val    = 1'b0;
        bus.in_acc_en = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int n);
        int k;
        k = 0;
        while (q_res.size() < n && k < 40) begin
            @(posedge clk);
            #2;
            k++;
        end
        check({tag, "_count"}, q_res.size(), n);
    endtask

    // Latency is reported as output cycle minus input cycle, input cycle being 0.
    task automatic pop_check(input string tag, input int ein, input int er, input int es,
                             input int el);
        if (q_res.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            check({tag, "_res"}, q_res.pop_front(), er);
            check({tag, "_sat"}, q_sat.pop_front(), es);
            check({tag, "_lat"}, q_edge.pop_front() - ein + 1, el);
        end
    endtask

    task automatic clear_q();
        q_edge.delete();
        q_res.delete();
        q_sat.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e2, e3;
        rst_n         = 1'b0;
        clk_en        = 1'b1;
        bus.in_ops    = '0;
        bus.in_op_msk = '0;
        bus.in_val    = 1'b0;
        bus.in_acc_en = 1'b0;
        bus.in_last   = 1'b0;
        idle(2);
        check("rst_val", bus.out_val, 0);
        check("rst_res", $signed(bus.out_res), 0);
        check("rst_sat", bus.out_sat, 0);
        rst_n = 1'b1;
        idle(2);
        clear_q();

        beat(ops5(1, 2, 3, 4, 5), 5'b11111, 1'b0, 1'b0, e0);
        wait_res("plain", 1);
        pop_check("plain", e0, 15, 0, 4);

        beat(ops5(1, 2, 3, 4, 5), 5'b10101, 1'b0, 1'b0, e0);
        wait_res("mask", 1);
        pop_check("mask", e0, 9, 0, 4);

        beat(ops5(1, 2, 3, 4, 5), 5'b00000, 1'b0, 1'b0, e0);
        wait_res("mask0", 1);
        pop_check("mask0", e0, 0, 0, 4);

        beat(fill(3), 5'b11111, 1'b0, 1'b1, e0);
        wait_res("lastnoacc", 1);
        pop_check("lastnoacc", e0, 15, 0, 4);

        beat(fill(32767), 5'b11111, 1'b0, 1'b0, e1);
        beat(fill(-32768), 5'b11111, 1'b0, 1'b0, e2);
        beat(ops5(1, 2, 3, 4, 5), 5'b11111, 1'b0, 1'b0, e3);
        wait_res("b2b", 3);
        pop_check("satpos", e1, 32767, 1, 4);
        pop_check("satneg", e2, -32768, 1, 4);
        pop_check("b2b_third", e3, 15, 0, 4);

        beat(fill(1), 5'b11111, 1'b1, 1'b0, e0);
        beat(fill(1), 5'b11111, 1'b1, 1'b0, e0);
        beat(fill(2), 5'b11111, 1'b0, 1'b0, e1);
        beat(fill(1), 5'b11111, 1'b1, 1'b1, e2);
        wait_res("grp", 2);
        idle(6);
        check("grp_total", q_res.size(), 2);
        pop_check("grp_inter", e1, 10, 0, 4);
        pop_check("grp_close", e2, 15, 0, 4);
        clear_q();

        beat(ops5(1, 2, 3, 4, 5), 5'b11111, 1'b0, 1'b0, e0);
        idle(1);
        clk_en = 1'b0;
        idle(3);
        clk_en = 1'b1;
        wait_res("stall", 1);
        idle(6);
        check("stall_total", q_res.size(), 1);
        pop_check("stall", e0, 15, 0, 7);
        clear_q();

        beat(fill(1), 5'b11111, 1'b1, 1'b0, e0);
        beat(fill(1), 5'b11111, 1'b1, 1'b0, e0);
        rst_n = 1'b0;
        #1;
        check("midrst_val", bus.out_val, 0);
        check("midrst_res", $signed(bus.out_res), 0);
        idle(2);
        rst_n = 1'b1;
        idle(6);
        check("midrst_none", q_res.size(), 0);
        clear_q();
        beat(fill(1), 5'b11111, 1'b1, 1'b1, e0);
        wait_res("single", 1);
        pop_check("single", e0, 5, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
